// File: rtl/transconv_requant.sv
// Requantiser for transposed-convolution accumulator pixels. Each pixel gets a rounding
// arithmetic shift, optional ReLU and int8 saturation. Four results are packed into an
// addressed 32-bit word, and the words are queued in a small FIFO for the feature-map
// write port.
module transconv_requant #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        cfg_width,
  input  logic [8:0]        cfg_height,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [19:0]       in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sat_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 33 + ADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Control and frame configuration
  state_e            state_q, state_d;
  logic [8:0]        width_q, width_d;
  logic [8:0]        height_q, height_d;
  logic [4:0]        shift_q, shift_d;
  logic              relu_q, relu_d;
  logic [ADDR_W-1:0] wpr_q, wpr_d;
  logic [8:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  // Stage 1: shifted value plus word bookkeeping
  logic               s1_valid_q, s1_valid_d;
  logic signed [20:0] s1_t_q, s1_t_d;
  logic [1:0]         s1_lane_q, s1_lane_d;
  logic               s1_push_q, s1_push_d;
  logic               s1_last_q, s1_last_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;

  // Stage 2: saturated byte
  logic              s2_valid_q, s2_valid_d;
  logic [7:0]        s2_byte_q, s2_byte_d;
  logic [1:0]        s2_lane_q, s2_lane_d;
  logic              s2_push_q, s2_push_d;
  logic              s2_last_q, s2_last_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;

  logic [31:0] pack_q, pack_d;
  logic [15:0] sat_count_q, sat_count_d;

  // Output FIFO
  logic [EntW-1:0] fifo_q [FIFO_DEPTH];
  logic [EntW-1:0] fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        start_acc;
  logic        last_col;
  logic        last_row;
  logic        pipe_empty;
  logic        push;
  logic        pop;
  logic [31:0] word;

  // Reserve three free entries: one word may complete in each of S1, S2 and the new pixel.
  assign in_ready   = (state_q == StRun) && (cnt_q <= CntW'(FIFO_DEPTH - 3));
  assign accept     = in_valid && in_ready;
  assign start_acc  = (state_q == StIdle) && start;
  assign last_col   = (col_q == width_q - 9'd1);
  assign last_row   = (row_q == height_q - 9'd1);
  assign pipe_empty = !s1_valid_q && !s2_valid_q && (cnt_q == '0);
  assign busy       = (state_q != StIdle);
  assign sat_count  = sat_count_q;

  assign out_valid  = (cnt_q != '0);
  assign {out_last, out_addr, out_data} = fifo_q[rd_ptr_q];

  // FSM next state, frame counters and running row base address
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    wpr_d      = wpr_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          width_d    = cfg_width;
          height_d   = cfg_height;
          shift_d    = cfg_shift;
          relu_d     = cfg_relu;
          wpr_d      = ADDR_W'(({1'b0, cfg_width} + 10'd3) >> 2);
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          state_d    = (cfg_width == 9'd0 || cfg_height == 9'd0) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (last_col) begin
            col_d      = '0;
            row_d      = row_q + 9'd1;
            row_base_d = row_base_q + wpr_q;
            if (last_row) begin
              state_d = StDrain;
            end
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
      StDrain: begin
        if (pipe_empty) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: rounding arithmetic shift at 21 bits so the rounding add cannot overflow
  always_comb begin
    logic signed [20:0] ext;
    logic signed [20:0] rnd;
    ext        = {in_pixel[19], in_pixel};
    rnd        = (shift_q != 5'd0) ? (21'sd1 <<< (shift_q - 5'd1)) : 21'sd0;
    s1_valid_d = accept;
    s1_t_d     = (ext + rnd) >>> shift_q;
    s1_lane_d  = col_q[1:0];
    s1_push_d  = (col_q[1:0] == 2'd3) || last_col;
    s1_last_d  = last_col && last_row;
    s1_addr_d  = row_base_q + ADDR_W'(col_q[8:2]);
  end

  // Stage 2: ReLU then saturation to int8; ReLU zeroing is not counted as clipping
  always_comb begin
    logic signed [20:0] t_relu;
    logic               clip;
    t_relu      = (relu_q && (s1_t_q < 21'sd0)) ? 21'sd0 : s1_t_q;
    clip        = 1'b0;
    if (t_relu > 21'sd127) begin
      s2_byte_d = 8'h7F;
      clip      = 1'b1;
    end else if (t_relu < -21'sd128) begin
      s2_byte_d = 8'h80;
      clip      = 1'b1;
    end else begin
      s2_byte_d = t_relu[7:0];
    end
    s2_valid_d  = s1_valid_q;
    s2_lane_d   = s1_lane_q;
    s2_push_d   = s1_push_q;
    s2_last_d   = s1_last_q;
    s2_addr_d   = s1_addr_q;
    sat_count_d = sat_count_q;
    if (start_acc) begin
      sat_count_d = '0;
    end else if (s1_valid_q && clip && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  // Packer merges the S2 byte into its lane; completed words go straight into the FIFO
  always_comb begin
    word   = pack_q | ({24'd0, s2_byte_q} << {s2_lane_q, 3'b000});
    push   = s2_valid_q && s2_push_q;
    pack_d = pack_q;
    if (s2_valid_q) begin
      pack_d = push ? 32'd0 : word;
    end
  end

  // FIFO pointers, occupancy and storage
  always_comb begin
    pop      = out_valid && out_ready;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {s2_last_q, s2_addr_q, word};
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Control and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      wpr_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      wpr_q      <= wpr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  // Pipeline, packer and saturation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_t_q      <= '0;
      s1_lane_q   <= '0;
      s1_push_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_addr_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_byte_q   <= '0;
      s2_lane_q   <= '0;
      s2_push_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_addr_q   <= '0;
      pack_q      <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_t_q      <= s1_t_d;
      s1_lane_q   <= s1_lane_d;
      s1_push_q   <= s1_push_d;
      s1_last_q   <= s1_last_d;
      s1_addr_q   <= s1_addr_d;
      s2_valid_q  <= s2_valid_d;
      s2_byte_q   <= s2_byte_d;
      s2_lane_q   <= s2_lane_d;
      s2_push_q   <= s2_push_d;
      s2_last_q   <= s2_last_d;
      s2_addr_q   <= s2_addr_d;
      pack_q      <= pack_d;
      sat_count_q <= sat_count_d;
    end
  end

  // FIFO registers; storage is cleared so out_data/out_addr read 0 after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_transconv_requant.sv
// Directed bench for transconv_requant: reset, rounding/ReLU/saturation, packing,
// addressing, back-pressure, empty frame and mid-frame reset.
module tb_transconv_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  cfg_width;
  logic [8:0]  cfg_height;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  int          px [0:255];
  int          npx;
  logic [31:0] got_data [0:63];
  logic [15:0] got_addr [0:63];
  logic        got_last [0:63];
  int          n_got;
  int          n_done;
  int          ready_low_stall;

  transconv_requant #(.FIFO_DEPTH(4), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  // Start a frame, stream px[0..npx-1], hold out_ready low for the first `stall` cycles,
  // and record every popped word until done pulses or the cycle budget runs out.
  task automatic run_frame(input int w, input int h, input int sh, input int relu,
                           input int stall);
    int idx;
    idx = 0;
    n_got = 0;
    n_done = 0;
    ready_low_stall = 0;
    @(negedge clk);
    cfg_width = 9'(w);
    cfg_height = 9'(h);
    cfg_shift = 5'(sh);
    cfg_relu = 1'(relu);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && n_done == 0; cyc++) begin
      in_valid = (idx < npx);
      in_pixel = (idx < npx) ? 20'(px[idx]) : 20'd0;
      out_ready = (cyc >= stall);
      #1;
      if (in_valid && in_ready) idx++;
      if (!in_ready && busy && idx < npx && cyc < stall) ready_low_stall++;
      if (out_valid && out_ready) begin
        if (n_got < 64) begin
          got_data[n_got] = out_data;
          got_addr[n_got] = out_addr;
          got_last[n_got] = out_last;
        end
        n_got++;
      end
      if (done) n_done++;
      if (n_done == 0) @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL frame_timeout: done pulses=%0d required=1", n_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    if (out_addr !== 16'd0) begin errors++; $display("FAIL rst_out_addr: got %h want 0", out_addr); end
    if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_sat: got %0d want 0", sat_count); end
    rst = 1'b0;
  endtask

  // 1,-2,127,128 with no shift: 128 clips to 0x7F
  task automatic test_basic;
    px[0] = 1; px[1] = -2; px[2] = 127; px[3] = 128; npx = 4;
    run_frame(4, 1, 0, 0, 0);
    checks += 5;
    if (n_got != 1) begin errors++; $display("FAIL basic_words: got %0d want 1", n_got); end
    if (got_data[0] !== 32'h7F7FFE01) begin
      errors++; $display("FAIL basic_data: got %h want 7f7ffe01", got_data[0]);
    end
    if (got_addr[0] !== 16'd0) begin errors++; $display("FAIL basic_addr: got %0d want 0", got_addr[0]); end
    if (got_last[0] !== 1'b1) begin errors++; $display("FAIL basic_last: got %b want 1", got_last[0]); end
    if (sat_count !== 16'd1) begin errors++; $display("FAIL basic_sat: got %0d want 1", sat_count); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  // 24 with shift 4 rounds to 2; width 5 gives a full and a one-lane word per row
  task automatic test_round;
    logic [31:0] exp_d [0:3];
    exp_d[0] = 32'h02020202; exp_d[1] = 32'h00000002;
    exp_d[2] = 32'h02020202; exp_d[3] = 32'h00000002;
    for (int i = 0; i < 10; i++) px[i] = 24;
    npx = 10;
    run_frame(5, 2, 4, 0, 0);
    checks++;
    if (n_got != 4) begin errors++; $display("FAIL round_words: got %0d want 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks += 3;
      if (got_data[i] !== exp_d[i]) begin
        errors++; $display("FAIL round_data[%0d]: got %h want %h", i, got_data[i], exp_d[i]);
      end
      if (got_addr[i] !== 16'(i)) begin
        errors++; $display("FAIL round_addr[%0d]: got %0d want %0d", i, got_addr[i], i);
      end
      if (got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL round_last[%0d]: got %b want %b", i, got_last[i], (i == 3));
      end
    end
    checks++;
    if (sat_count !== 16'd0) begin errors++; $display("FAIL round_sat: got %0d want 0", sat_count); end
  endtask

  // shift 2 with ReLU: -5->0, 5->1, 6->2, large negative->0, no clipping counted
  task automatic test_relu;
    px[0] = -5; px[1] = 5; px[2] = 6; px[3] = -100000; npx = 4;
    run_frame(4, 1, 2, 1, 0);
    checks += 3;
    if (n_got != 1) begin errors++; $display("FAIL relu_words: got %0d want 1", n_got); end
    if (got_data[0] !== 32'h00020100) begin
      errors++; $display("FAIL relu_data: got %h want 00020100", got_data[0]);
    end
    if (sat_count !== 16'd0) begin errors++; $display("FAIL relu_sat: got %0d want 0", sat_count); end
  endtask

  // 8x8 frame with the consumer stalled for 20 cycles; pixel i becomes byte i
  task automatic test_back_to_back;
    logic [31:0] exp_w;
    for (int i = 0; i < 64; i++) px[i] = i;
    npx = 64;
    run_frame(8, 8, 0, 0, 20);
    checks += 2;
    if (n_got != 16) begin errors++; $display("FAIL bp_words: got %0d want 16", n_got); end
    if (ready_low_stall == 0) begin
      errors++; $display("FAIL bp_in_ready_drop: got %0d low cycles want >0", ready_low_stall);
    end
    for (int k = 0; k < 16; k++) begin
      exp_w = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
      checks += 3;
      if (got_data[k] !== exp_w) begin
        errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, got_data[k], exp_w);
      end
      if (got_addr[k] !== 16'(k)) begin
        errors++; $display("FAIL bp_addr[%0d]: got %0d want %0d", k, got_addr[k], k);
      end
      if (got_last[k] !== (k == 15)) begin
        errors++; $display("FAIL bp_last[%0d]: got %b want %b", k, got_last[k], (k == 15));
      end
    end
  endtask

  // Zero height: busy and done both high for exactly the cycle after start
  task automatic test_empty;
    @(negedge clk);
    cfg_width = 9'd4;
    cfg_height = 9'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b want 1", busy); end
    if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b want 1", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b want 0", out_valid); end
    @(negedge clk);
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_end: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL empty_done_end: got %b want 0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid_end: got %b want 0", out_valid); end
  endtask

  // Reset with two words queued, then a clean frame afterwards
  task automatic test_reset_mid;
    int idx;
    idx = 0;
    @(negedge clk);
    cfg_width = 9'd8;
    cfg_height = 9'd2;
    cfg_shift = 5'd0;
    cfg_relu = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      in_valid = 1'b1;
      in_pixel = 20'(idx);
      #1;
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b want 1", out_valid); end
    if (out_data !== 32'h03020100) begin
      errors++; $display("FAIL mid_head: got %h want 03020100", out_data);
    end
    rst = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    px[0] = 1; px[1] = -2; px[2] = 127; px[3] = 128; npx = 4;
    run_frame(4, 1, 0, 0, 0);
    checks += 3;
    if (n_got != 1) begin errors++; $display("FAIL mid_again_words: got %0d want 1", n_got); end
    if (got_data[0] !== 32'h7F7FFE01) begin
      errors++; $display("FAIL mid_again_data: got %h want 7f7ffe01", got_data[0]);
    end
    if (got_addr[0] !== 16'd0) begin
      errors++; $display("FAIL mid_again_addr: got %0d want 0", got_addr[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_width = '0;
    cfg_height = '0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b0;
    npx = 0;
    test_reset();
    test_basic();
    test_round();
    test_relu();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
